multi_rate_counter: RTL and testbench
=====================================

Name: multi_rate_counter

Overview:
Parametrised, multi-rate up/down counter of configurable width. A free-running prescaler on clk_100MHz produces the update tick. Four programmable tick periods are selectable at run time. Each tick applies a programmable step, with synchronous load, wrap detection and an optional saturating mode. Used as the general timebase/event counter feeding display and control logic.

Parameters:
WIDTH, 8, counter width in bits (2..32)
DIV_W, 32, prescaler register width
DIV0, 100000000, mode 0 tick period in clk cycles (1 s at 100 MHz)
DIV1, 25000000, mode 1 tick period (250 ms)
DIV2, 10000000, mode 2 tick period (100 ms)
DIV3, 1000000, mode 3 tick period (10 ms)

Ports:
clk_100MHz  in   1      system clock, 100 MHz
rst_n       in   1      asynchronous, active-low reset
en          in   1      count enable; low freezes prescaler and count
mode        in   2      tick period select (DIV0..DIV3)
up          in   1      1 = count up, 0 = count down
step        in   WIDTH  increment/decrement applied per tick
load        in   1      synchronous load strobe
load_val    in   WIDTH  value loaded on load
count       out  WIDTH  counter value (registered)
tick        out  1      one-cycle pulse, registered with each count update
wrap        out  1      one-cycle pulse when an update crosses the range boundary

Behaviour:
- Reset (async, rst_n=0): count=0, tick=0, wrap=0, prescaler=0, mode_q=0. Release is synchronous to clk_100MHz.
- Prescaler counts 0..DIVm-1 while en=1, where m=mode. When prescaler==DIVm-1 and en=1, the prescaler returns to 0 and a tick event fires.
- Tick event: count updates on that edge. tick=1 for exactly that one cycle, aligned with the new count value. Tick spacing is exactly DIVm cycles.
- Up update: sum=count+step computed in WIDTH+1 bits. count<=sum[WIDTH-1:0]; wrap=sum[WIDTH].
- Down update: count<=count-step mod 2^WIDTH; wrap=1 iff step>count.
- step=0: tick still pulses, count is unchanged, wrap=0.
- Priority is load > mode change > tick.
  - load=1: count<=load_val, prescaler<=0, tick=0, wrap=0, regardless of en.
  - Mode change: mode_q registers mode. If mode!=mode_q, the prescaler clears to 0 and no tick fires that cycle. The new period runs in full from the clear.
- en=0: prescaler and count hold, tick=0, wrap=0. A pending period resumes where it stopped.
- up and step are sampled only on the tick cycle. Changes between ticks have no effect.
- tick and wrap are 0 on every cycle without an update.
- A divider value of 1 gives a tick every enabled cycle.

Optional Feature:
Macro MULTI_RATE_COUNTER_SATURATE_EN.
- Defined:
  - An up update that would exceed 2^WIDTH-1 clamps count to 2^WIDTH-1.
  - A down update with step>count clamps count to 0.
  - wrap pulses on each clamped tick, including repeated ticks at the limit.
  - Load is unaffected.
- Not defined: modulo wrap as above. The saturation logic is fully absent from the netlist.

Test Plan:
- WIDTH=8, DIV0=4, mode=0, up=1, step=1, en=1 from reset -> count=0 for 4 cycles; then 1,2,3 at 4-cycle spacing; tick pulses once per 4 cycles, aligned with the count changes.
- DIV1=2, mode=1, step=4, count loaded to 252 -> next tick count=0 with wrap=1. Next tick count=4, wrap=0. Under SATURATE_EN: count=255 with wrap=1, and stays 255 with wrap=1 on the next tick.
- up=0, step=3, count=2 -> next tick count=255 with wrap=1. Under SATURATE_EN: count=0 with wrap=1.
- Mode switches 0->1 mid-period (prescaler=2, DIV0=4) -> prescaler clears and no tick that cycle. The first mode-1 tick arrives exactly DIV1 cycles later.
- load=1 with load_val=0x5A on the same cycle a tick is due -> count=0x5A, tick=0, wrap=0. The next tick is DIVm cycles later and gives 0x5A+step.
- rst_n asserted mid-period with count=0x33 and en=0 toggling -> count=0, tick=0 and wrap=0 immediately (async). Counting restarts a full period after release.

Source files
------------

// File: rtl/multi_rate_counter.sv
// Multi-rate up/down counter driven by a prescaled tick with four selectable periods.
// Define MULTI_RATE_COUNTER_SATURATE_EN to clamp at the range limits instead of wrapping.
module multi_rate_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 32,
  parameter int unsigned DIV0  = 100000000,
  parameter int unsigned DIV1  = 25000000,
  parameter int unsigned DIV2  = 10000000,
  parameter int unsigned DIV3  = 1000000
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap
);

  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic [DIV_W-1:0] div_last_c;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] count_d;
  logic             tick_d;
  logic             wrap_d;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] diff_c;
  logic             borrow_c;

  // Terminal prescaler value for the registered mode
  always_comb begin
    div_last_c = DIV_W'(DIV0 - 1);
    unique case (mode_q)
      2'd0: div_last_c = DIV_W'(DIV0 - 1);
      2'd1: div_last_c = DIV_W'(DIV1 - 1);
      2'd2: div_last_c = DIV_W'(DIV2 - 1);
      2'd3: div_last_c = DIV_W'(DIV3 - 1);
      default: div_last_c = DIV_W'(DIV0 - 1);
    endcase
  end

  assign sum_c    = {1'b0, count} + {1'b0, step};
  assign diff_c   = count - step;
  assign borrow_c = (step > count);

  // Next-state: load beats a mode change, which beats a tick
  always_comb begin
    presc_d = presc_q;
    count_d = count;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
      presc_d = '0;
    end else if (mode != mode_q) begin
      presc_d = '0;
    end else if (en) begin
      if (presc_q == div_last_c) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (up) begin
`ifdef MULTI_RATE_COUNTER_SATURATE_EN
          if (sum_c[WIDTH]) begin
            count_d = '1;
            wrap_d  = 1'b1;
          end else begin
            count_d = sum_c[WIDTH-1:0];
          end
`else
          count_d = sum_c[WIDTH-1:0];
          wrap_d  = sum_c[WIDTH];
`endif
        end else begin
`ifdef MULTI_RATE_COUNTER_SATURATE_EN
          if (borrow_c) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = diff_c;
          end
`else
          count_d = diff_c;
          wrap_d  = borrow_c;
`endif
        end
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      mode_q  <= 2'd0;
      count   <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mode_q  <= mode;
      count   <= count_d;
      tick    <= tick_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_multi_rate_counter.sv
// Self-checking bench for multi_rate_counter: directed sequences, a vector table and
// random stimulus compared against an integer-arithmetic reference model.
module tb_multi_rate_counter;

  localparam int unsigned WIDTH = 8;

  logic             clk_100MHz = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic             up;
  logic [WIDTH-1:0] step;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_cnt, m_phase, m_mq, m_tick, m_wrap;

  multi_rate_counter #(
    .WIDTH(WIDTH), .DIV_W(32), .DIV0(4), .DIV1(2), .DIV2(3), .DIV3(1)
  ) dut (
    .clk_100MHz(clk_100MHz), .rst_n(rst_n), .en(en), .mode(mode), .up(up),
    .step(step), .load(load), .load_val(load_val), .count(count), .tick(tick), .wrap(wrap)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int div_of(input int m);
    case (m)
      0: return 4;
      1: return 2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_mq = 0; m_tick = 0; m_wrap = 0;
  endtask

  // One clock of the behavioural model, using the inputs the DUT just sampled
  task automatic model_step();
    int r;
    m_tick = 0;
    m_wrap = 0;
    if (load) begin
      m_cnt = int'(load_val);
      m_phase = 0;
    end else if (int'(mode) != m_mq) begin
      m_phase = 0;
    end else if (en) begin
      m_phase++;
      if (m_phase >= div_of(m_mq)) begin
        m_phase = 0;
        m_tick = 1;
        r = up ? m_cnt + int'(step) : m_cnt - int'(step);
`ifdef MULTI_RATE_COUNTER_SATURATE_EN
        if (r > 255) begin m_cnt = 255; m_wrap = 1; end
        else if (r < 0) begin m_cnt = 0; m_wrap = 1; end
        else m_cnt = r;
`else
        m_wrap = (r > 255 || r < 0) ? 1 : 0;
        m_cnt = (r + 256) % 256;
`endif
      end
    end
    m_mq = int'(mode);
  endtask

  task automatic clk_cycle();
    @(posedge clk_100MHz);
    #1;
    model_step();
    check("model_count", int'(count), m_cnt);
    check("model_tick", int'(tick), m_tick);
    check("model_wrap", int'(wrap), m_wrap);
  endtask

  task automatic wait_tick(input string name, output int ncyc);
    ncyc = 0;
    do begin
      clk_cycle();
      ncyc++;
    end while (!tick && ncyc < 20);
    if (!tick) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got no tick in 20 cycles, expected a tick", name);
    end
  endtask

  typedef struct {
    logic [7:0] lv;
    logic       up;
    logic [7:0] st;
    int         exp_mod;
    int         wrap_mod;
    int         exp_sat;
    int         wrap_sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nc;
    vecs[0] = '{8'd10,  1'b1, 8'd5,   15,  0, 15,  0};
    vecs[1] = '{8'd250, 1'b1, 8'd10,  4,   1, 255, 1};
    vecs[2] = '{8'd255, 1'b1, 8'd1,   0,   1, 255, 1};
    vecs[3] = '{8'd0,   1'b0, 8'd1,   255, 1, 0,   1};
    vecs[4] = '{8'd100, 1'b0, 8'd100, 0,   0, 0,   0};
    vecs[5] = '{8'd7,   1'b1, 8'd0,   7,   0, 7,   0};
    vecs[6] = '{8'd128, 1'b1, 8'd127, 255, 0, 255, 0};
    vecs[7] = '{8'd3,   1'b0, 8'd4,   255, 1, 0,   1};

    rst_n = 1'b0; en = 1'b1; mode = 2'd0; up = 1'b1; step = 8'd1;
    load = 1'b0; load_val = 8'd0;
    model_reset();
    #3;
    check("reset_count", int'(count), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_wrap", int'(wrap), 0);

    // Basic count-up at DIV0=4
    #9 rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      clk_cycle();
      check("seq_up_count", int'(count), i / 4);
      check("seq_up_tick", int'(tick), (i % 4 == 0) ? 1 : 0);
    end

    // Up wrap from 252 by 4 at DIV1=2
    mode = 2'd1;
    clk_cycle();
    load = 1'b1; load_val = 8'd252;
    clk_cycle();
    check("load_252", int'(count), 252);
    load = 1'b0; up = 1'b1; step = 8'd4;
    wait_tick("wrap_up_1", nc);
    check("wrap_up_spacing", nc, 2);
`ifdef MULTI_RATE_COUNTER_SATURATE_EN
    check("wrap_up_count1", int'(count), 255);
    check("wrap_up_wrap1", int'(wrap), 1);
    wait_tick("wrap_up_2", nc);
    check("wrap_up_count2", int'(count), 255);
    check("wrap_up_wrap2", int'(wrap), 1);
`else
    check("wrap_up_count1", int'(count), 0);
    check("wrap_up_wrap1", int'(wrap), 1);
    wait_tick("wrap_up_2", nc);
    check("wrap_up_count2", int'(count), 4);
    check("wrap_up_wrap2", int'(wrap), 0);
`endif

    // Down underflow: 2 - 3
    load = 1'b1; load_val = 8'd2;
    clk_cycle();
    load = 1'b0; up = 1'b0; step = 8'd3;
    wait_tick("wrap_dn", nc);
`ifdef MULTI_RATE_COUNTER_SATURATE_EN
    check("wrap_dn_count", int'(count), 0);
`else
    check("wrap_dn_count", int'(count), 255);
`endif
    check("wrap_dn_wrap", int'(wrap), 1);

    // Mode switch 0->1 with the prescaler at 2
    mode = 2'd0; load = 1'b1; load_val = 8'd0; up = 1'b1; step = 8'd1;
    clk_cycle();
    load = 1'b0;
    clk_cycle();
    clk_cycle();
    mode = 2'd1;
    clk_cycle();
    check("mode_sw_notick", int'(tick), 0);
    clk_cycle();
    check("mode_sw_tick_early", int'(tick), 0);
    clk_cycle();
    check("mode_sw_tick", int'(tick), 1);
    check("mode_sw_count", int'(count), 1);

    // Load on the cycle a tick is due
    clk_cycle();
    load = 1'b1; load_val = 8'h5A;
    clk_cycle();
    check("load_tick_count", int'(count), 'h5A);
    check("load_tick_tick", int'(tick), 0);
    check("load_tick_wrap", int'(wrap), 0);
    load = 1'b0;
    wait_tick("load_next", nc);
    check("load_next_spacing", nc, 2);
    check("load_next_count", int'(count), 'h5B);

    // Async reset mid-period with en toggling
    mode = 2'd0; load = 1'b1; load_val = 8'h33;
    clk_cycle();
    check("pre_rst_count", int'(count), 'h33);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = (i % 2 == 0);
      clk_cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_count", int'(count), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_wrap", int'(wrap), 0);
    en = 1'b0;
    @(posedge clk_100MHz);
    en = 1'b1;
    @(posedge clk_100MHz);
    #3 rst_n = 1'b1; en = 1'b1; mode = 2'd0; up = 1'b1; step = 8'd1;
    for (int i = 1; i <= 4; i++) begin
      clk_cycle();
      check("post_rst_tick", int'(tick), (i == 4) ? 1 : 0);
    end
    check("post_rst_count", int'(count), 1);

    // Vector table at DIV3=1 (tick every enabled cycle)
    for (int i = 0; i < 8; i++) begin
      mode = 2'd3; load = 1'b1; load_val = vecs[i].lv; en = 1'b0;
      clk_cycle();
      load = 1'b0; up = vecs[i].up; step = vecs[i].st; en = 1'b1;
      clk_cycle();
      check("vec_tick", int'(tick), 1);
`ifdef MULTI_RATE_COUNTER_SATURATE_EN
      check("vec_count", int'(count), vecs[i].exp_sat);
      check("vec_wrap", int'(wrap), vecs[i].wrap_sat);
`else
      check("vec_count", int'(count), vecs[i].exp_mod);
      check("vec_wrap", int'(wrap), vecs[i].wrap_mod);
`endif
    end

    // Random stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom % 32 == 0);
      load_val = 8'($urandom);
      if ($urandom % 40 == 0) mode = 2'($urandom);
      en = ($urandom % 8 != 0);
      up = 1'($urandom);
      step = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      clk_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
